// File: rtl/imem_loader_ctrl.sv
// Fetch-stage loader: packs rx bytes into 32-bit words for instruction memory, then drives the PC enable.
// Optional IMEM_LOADER_CHECKSUM_EN adds checksum_o, the XOR of every word written by the last load.
module imem_loader_ctrl #(
  parameter int                 NB_DATA   = 32,
  parameter int                 NB_ADDR   = 7,
  parameter int                 NB_BYTE   = 8,
  parameter logic [NB_DATA-1:0] HALT_WORD = 32'hFFFFFFFF
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic [NB_BYTE-1:0] rx_data_i,
  input  logic               rx_valid_i,
  input  logic               run_i,
  input  logic               step_i,
  input  logic               halt_i,
  output logic               en_write_o,
  output logic [NB_ADDR-1:0] addr_write_o,
  output logic [NB_DATA-1:0] data_o,
  output logic               en_read_o,
  output logic               enable_o,
  output logic               load_done_o,
  output logic [NB_ADDR:0]   word_count_o
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,output logic [NB_DATA-1:0] checksum_o
`endif
);

  // state | meaning
  // IDLE  | after reset, waiting for the first load_i
  // LOAD  | collecting bytes of the current word (MSB first)
  // WRITE | one-cycle instruction memory write of the assembled word
  // READY | program loaded, PC held
  // RUN   | PC free-running until halt_i
  // STEP  | PC enabled for a single cycle
  typedef enum logic [2:0] {
    ST_IDLE, ST_LOAD, ST_WRITE, ST_READY, ST_RUN, ST_STEP
  } state_t;

  localparam logic [NB_ADDR-1:0] ADDR_MAX = '1;
  localparam logic [NB_ADDR-1:0] ADDR_ONE = {{(NB_ADDR-1){1'b0}}, 1'b1};
  localparam logic [NB_ADDR:0]   CNT_ONE  = {{NB_ADDR{1'b0}}, 1'b1};

  state_t               state, state_nxt;
  logic [NB_ADDR-1:0]   addr;
  logic [1:0]           byte_cnt;
  logic [NB_DATA-1:0]   word;
  logic                 word_last;
  logic                 clr_load;

  assign word_last = (word == HALT_WORD) || (addr == ADDR_MAX);

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clr_load  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (load_i) begin
          state_nxt = ST_LOAD;
          clr_load  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (load_i) begin
          state_nxt = ST_LOAD;
          clr_load  = 1'b1;
        end else if (rx_valid_i && byte_cnt == 2'd3) begin
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (load_i) begin
          state_nxt = ST_LOAD;
          clr_load  = 1'b1;
        end else if (word_last) begin
          state_nxt = ST_READY;
        end else begin
          state_nxt = ST_LOAD;
        end
      end
      ST_READY: begin
        // run beats step, both beat a reload
        if (run_i) begin
          state_nxt = ST_RUN;
        end else if (step_i) begin
          state_nxt = ST_STEP;
        end else if (load_i) begin
          state_nxt = ST_LOAD;
          clr_load  = 1'b1;
        end
      end
      ST_RUN: begin
        if (halt_i) state_nxt = ST_READY;
      end
      ST_STEP: begin
        state_nxt = ST_READY;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      addr         <= '0;
      byte_cnt     <= '0;
      word         <= '0;
      word_count_o <= '0;
    end else if (clr_load) begin
      addr         <= '0;
      byte_cnt     <= '0;
      word_count_o <= '0;
    end else begin
      if (state == ST_WRITE) word_count_o <= word_count_o + CNT_ONE;
      // A byte arriving during a non-final WRITE becomes byte 0 of the next word
      if (rx_valid_i && (state == ST_LOAD || (state == ST_WRITE && !word_last))) begin
        word     <= {word[NB_DATA-NB_BYTE-1:0], rx_data_i};
        byte_cnt <= byte_cnt + 2'd1;
      end
      if (state == ST_WRITE && !word_last) addr <= addr + ADDR_ONE;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i)                 checksum_o <= '0;
    else if (clr_load)           checksum_o <= '0;
    else if (state == ST_WRITE)  checksum_o <= checksum_o ^ word;
  end
`endif

  assign en_write_o   = (state == ST_WRITE);
  assign addr_write_o = en_write_o ? addr : '0;
  assign data_o       = en_write_o ? word : '0;
  assign enable_o     = (state == ST_RUN) || (state == ST_STEP);
  assign load_done_o  = (state == ST_READY) || enable_o;
  assign en_read_o    = load_done_o;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// Scoreboard bench for imem_loader_ctrl: expected writes are queued by the stimulus, a negedge monitor checks them.
// Build with IMEM_LOADER_CHECKSUM_EN defined to also cover checksum_o.
module tb_imem_loader_ctrl;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        load_i, rx_valid_i, run_i, step_i, halt_i;
  logic [7:0]  rx_data_i;
  logic        en_write_o, en_read_o, enable_o, load_done_o;
  logic [6:0]  addr_write_o;
  logic [31:0] data_o;
  logic [7:0]  word_count_o;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] checksum_o;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [38:0] exp_q[$];

  imem_loader_ctrl dut (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .load_i       (load_i),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .run_i        (run_i),
    .step_i       (step_i),
    .halt_i       (halt_i),
    .en_write_o   (en_write_o),
    .addr_write_o (addr_write_o),
    .data_o       (data_o),
    .en_read_o    (en_read_o),
    .enable_o     (enable_o),
    .load_done_o  (load_done_o),
    .word_count_o (word_count_o)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,.checksum_o  (checksum_o)
`endif
  );

  always #5 clock_i = ~clock_i;

  // Write monitor: every en_write_o pulse must match the head of the scoreboard queue
  always @(negedge clock_i) begin
    if (en_write_o) begin
      logic [38:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr=%0d data=%h, required no write", addr_write_o, data_o);
      end else begin
        e = exp_q.pop_front();
        if ({addr_write_o, data_o} !== e) begin
          n_err++;
          $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                   addr_write_o, data_o, e[38:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic push_exp(input logic [6:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic pulse_load();
    load_i = 1'b1;
    tick();
    load_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    tick();
    rx_valid_i = 1'b0;
    if (gap) tick();
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8], gap);
  endtask

  // Holds step_i for hold edges, then counts enable_o cycles over total cycles
  task automatic count_steps(input int hold, input int total, output int cnt);
    cnt    = 0;
    step_i = 1'b1;
    for (int i = 0; i < total; i++) begin
      @(posedge clock_i);
      #1;
      if (i == hold - 1) step_i = 1'b0;
      @(negedge clock_i);
      if (enable_o) cnt++;
    end
  endtask

  task automatic chk_ready(input string tag, input logic [7:0] cnt);
    repeat (3) tick();
    @(negedge clock_i);
    chk({tag, "_load_done"}, 32'(load_done_o), 32'd1);
    chk({tag, "_en_read"}, 32'(en_read_o), 32'd1);
    chk({tag, "_enable"}, 32'(enable_o), 32'd0);
    chk({tag, "_word_count"}, 32'(word_count_o), 32'(cnt));
    chk({tag, "_queue_drained"}, exp_q.size(), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en_write"}, 32'(en_write_o), 32'd0);
    chk({tag, "_addr_write"}, 32'(addr_write_o), 32'd0);
    chk({tag, "_data"}, data_o, 32'd0);
    chk({tag, "_en_read"}, 32'(en_read_o), 32'd0);
    chk({tag, "_enable"}, 32'(enable_o), 32'd0);
    chk({tag, "_load_done"}, 32'(load_done_o), 32'd0);
    chk({tag, "_word_count"}, 32'(word_count_o), 32'd0);
  endtask

  initial begin
    int cnt;
    logic [7:0] k;
    reset_i = 1'b1; load_i = 1'b0; rx_valid_i = 1'b0; rx_data_i = '0;
    run_i = 1'b0; step_i = 1'b0; halt_i = 1'b0;
    #3;
    chk_all_zero("reset");
    tick();
    reset_i = 1'b0;
    tick();

    // Reset in the middle of a word: nothing may be written
    pulse_load();
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    reset_i = 1'b1;
    #2;
    chk_all_zero("mid_load_reset");
    tick();
    reset_i = 1'b0;
    repeat (4) tick();
    @(negedge clock_i);
    chk("post_reset_load_done", 32'(load_done_o), 32'd0);

    // Gapped byte stream ending in the halt word
    push_exp(7'd0, 32'h20080005);
    push_exp(7'd1, 32'hFFFFFFFF);
    tick();
    pulse_load();
    send_word(32'h20080005, 1'b1);
    send_word(32'hFFFFFFFF, 1'b1);
    chk_ready("halt_load", 8'd2);

    // Single step pulse
    count_steps(1, 6, cnt);
    chk("single_step_cycles", cnt, 32'd1);

    // step_i held: one step per READY->STEP pass
    count_steps(6, 8, cnt);
    chk("held_step_cycles", cnt, 32'd3);

    // run and step together: run wins, load ignored in RUN, halt returns to READY
    tick();
    run_i = 1'b1; step_i = 1'b1;
    tick();
    run_i = 1'b0; step_i = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock_i);
      if (enable_o) cnt++;
      tick();
    end
    chk("run_enable_cycles", cnt, 32'd5);
    pulse_load();
    @(negedge clock_i);
    chk("run_ignores_load", 32'(load_done_o & enable_o), 32'd1);
    tick();
    halt_i = 1'b1;
    @(negedge clock_i);
    chk("run_enable_at_halt", 32'(enable_o), 32'd1);
    tick();
    halt_i = 1'b0;
    @(negedge clock_i);
    chk("enable_after_halt", 32'(enable_o), 32'd0);
    chk("ready_after_halt", 32'(load_done_o), 32'd1);

    // Back-to-back bytes: byte arriving in WRITE must not be lost
    push_exp(7'd0, 32'h11223344);
    push_exp(7'd1, 32'h55667788);
    push_exp(7'd2, 32'hFFFFFFFF);
    tick();
    pulse_load();
    send_word(32'h11223344, 1'b0);
    send_word(32'h55667788, 1'b0);
    send_word(32'hFFFFFFFF, 1'b0);
    chk_ready("continuous", 8'd3);

    // Restart mid-word: partial bytes are thrown away
    push_exp(7'd0, 32'hAABBCCDD);
    push_exp(7'd1, 32'hFFFFFFFF);
    pulse_load();
    send_byte(8'h99, 1'b0);
    send_byte(8'h98, 1'b0);
    pulse_load();
    send_word(32'hAABBCCDD, 1'b0);
    send_word(32'hFFFFFFFF, 1'b1);
    chk_ready("restart", 8'd2);

    // No halt word: fills all 128 addresses, extra word is ignored
    for (int i = 0; i < 128; i++) begin
      k = 8'(i);
      push_exp(7'(i), {8'h5A, k, 8'hC3, ~k});
    end
    pulse_load();
    for (int i = 0; i < 128; i++) begin
      k = 8'(i);
      send_word({8'h5A, k, 8'hC3, ~k}, 1'b0);
    end
    send_word(32'h01020304, 1'b0);
    chk_ready("full_memory", 8'd128);

`ifdef IMEM_LOADER_CHECKSUM_EN
    push_exp(7'd0, 32'h0000000F);
    push_exp(7'd1, 32'h000000F0);
    push_exp(7'd2, 32'hFFFFFFFF);
    pulse_load();
    @(negedge clock_i);
    chk("checksum_cleared", checksum_o, 32'd0);
    tick();
    send_word(32'h0000000F, 1'b0);
    send_word(32'h000000F0, 1'b0);
    send_word(32'hFFFFFFFF, 1'b0);
    chk_ready("checksum_load", 8'd3);
    chk("checksum", checksum_o, 32'hFFFFFF00);
`endif

    tick();
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
